// File: rtl/audio_sample_writer_pkg.sv
// Shared constants and types for the audio sample writer.
package audio_sample_writer_pkg;

  // Width of one codec sample word (both channels).
  localparam int SAMPLE_W = 32;

  // Clock cycles per output sample for a 50 MHz clock and a 48 kHz codec.
  localparam int DEFAULT_SAMPLE_DIV = 1042;

  // Codec write handshake states.
  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } wr_state_t;

endpackage

// File: rtl/audio_sample_writer_sample_fifo.sv
// Small synchronous FIFO buffering scaled samples ahead of the codec.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module audio_sample_writer_sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes all buffered samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_sample_writer.sv
// Decimates the voice mixer sum to the codec rate, scales and saturates it,
// buffers it and hands it to the codec through its write/allowed handshake.
module audio_sample_writer
  import audio_sample_writer_pkg::*;
#(
  parameter int SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
  parameter int SHIFT      = 3,
  parameter int SAT_W      = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] mix_in,
  input  logic                       mute,
  input  logic                       audio_out_allowed,
  output logic                       write_audio_out,
  output logic signed [SAMPLE_W-1:0] left_channel_audio_out,
  output logic signed [SAMPLE_W-1:0] right_channel_audio_out,
  output logic                       sample_tick,
  output logic [CNT_W-1:0]           dropped_count
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = (32'sd1 <<< (SAT_W - 1)) - 32'sd1;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = -(32'sd1 <<< (SAT_W - 1));

  // Headroom shift followed by a clamp to SAT_W signed bits, sign-extended.
  function automatic logic signed [SAMPLE_W-1:0] scale_sat(
    input logic signed [SAMPLE_W-1:0] x
  );
    logic signed [SAMPLE_W-1:0] s;
    s = x >>> SHIFT;
    if (s > SAT_MAX)      return SAT_MAX;
    else if (s < SAT_MIN) return SAT_MIN;
    else                  return s;
  endfunction

  logic [DIV_W-1:0]           div_cnt;
  logic                       vld_p0;
  logic signed [SAMPLE_W-1:0] sample_p0;
  logic [SAMPLE_W-1:0]        fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       pop;
  logic                       drop;
  logic signed [SAMPLE_W-1:0] sample_p1;
  wr_state_t                  state;
  wr_state_t                  next_state;

  // Sample-rate divider: counts 0..SAMPLE_DIV-1 and wraps.
  always_ff @(posedge clock) begin
    if (reset || div_cnt == DIV_LAST) div_cnt <= '0;
    else                              div_cnt <= div_cnt + 1'b1;
  end

  assign sample_tick = (div_cnt == DIV_LAST);

  // ---- p0: capture at the sample instant ----
  assign vld_p0    = sample_tick;
  assign sample_p0 = mute ? '0 : scale_sat(mix_in);
  assign drop      = vld_p0 && fifo_full && !pop;

  audio_sample_writer_sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (vld_p0),
    .din   (sample_p0),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Saturating count of samples lost because the buffer was full.
  always_ff @(posedge clock) begin
    if (reset)                             dropped_count <= '0;
    else if (drop && dropped_count != '1)  dropped_count <= dropped_count + 1'b1;
  end

  // Handshake state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and pop decision; a write always runs WRITE then GAP.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && audio_out_allowed) begin
          pop        = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE:   next_state = GAP;
      GAP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---- p1: popped sample held on the codec outputs ----
  always_ff @(posedge clock) begin
    if (reset)    sample_p1 <= '0;
    else if (pop) sample_p1 <= fifo_dout;
  end

  assign write_audio_out         = (state == WRITE);
  assign left_channel_audio_out  = sample_p1;
  assign right_channel_audio_out = sample_p1;

endmodule

// File: tb/tb_audio_sample_writer.sv
// Scoreboard bench for audio_sample_writer with SAMPLE_DIV=4.
module tb_audio_sample_writer;

  localparam int DIV = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic signed [31:0] mix_in;
  logic               mute;
  logic               allowed;
  logic               write_audio_out;
  logic signed [31:0] left_out;
  logic signed [31:0] right_out;
  logic               sample_tick;
  logic [15:0]        dropped_count;

  // Second instance: never allowed to write, 2-bit drop counter.
  logic               write2;
  logic signed [31:0] left2;
  logic signed [31:0] right2;
  logic               tick2;
  logic [1:0]         drop2;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  int          wr_cyc[$];
  bit          lat_chk = 1'b1;
  bit          have_tick = 1'b0;
  int          last_tick = 0;

  audio_sample_writer #(
    .SAMPLE_DIV (DIV), .SHIFT (3), .SAT_W (24), .FIFO_DEPTH (4), .CNT_W (16)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .mix_in                  (mix_in),
    .mute                    (mute),
    .audio_out_allowed       (allowed),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_out),
    .right_channel_audio_out (right_out),
    .sample_tick             (sample_tick),
    .dropped_count           (dropped_count)
  );

  audio_sample_writer #(
    .SAMPLE_DIV (DIV), .SHIFT (0), .SAT_W (24), .FIFO_DEPTH (4), .CNT_W (2)
  ) dut2 (
    .clock                   (clock),
    .reset                   (reset),
    .mix_in                  (mix_in),
    .mute                    (mute),
    .audio_out_allowed       (1'b0),
    .write_audio_out         (write2),
    .left_channel_audio_out  (left2),
    .right_channel_audio_out (right2),
    .sample_tick             (tick2),
    .dropped_count           (drop2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: tick period, latency and scoreboard comparison on every strobe.
  always @(negedge clock) begin
    if (reset) begin
      have_tick = 1'b0;
    end else begin
      if (sample_tick) begin
        if (have_tick) chk("tick_period", cyc - last_tick, DIV);
        have_tick = 1'b1;
        last_tick = cyc;
      end
      if (write_audio_out) begin
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got L=0x%08h with no sample expected", left_out);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("left_value", left_out, e);
          chk("right_value", right_out, e);
        end
        if (lat_chk) chk("tick_to_write_latency", cyc - last_tick, 2);
      end
    end
  end

  // Drive one sample for the next tick (possibly the current cycle) and
  // record its expected codec value; returns one cycle after the tick.
  task automatic do_tick(input logic signed [31:0] v, input logic m, input bit exp_on,
                         input logic [31:0] e, output int waits);
    mix_in = v;
    mute   = m;
    waits  = 0;
    while (!sample_tick && waits < 3 * DIV) begin
      @(negedge clock);
      waits++;
    end
    if (!sample_tick) begin
      n_chk++;
      n_fail++;
      $display("FAIL tick_timeout: no sample_tick within %0d cycles", waits);
    end else if (exp_on) begin
      exp_q.push_back(e);
    end
    @(negedge clock);
  endtask

  initial begin
    int w;
    int n0;
    reset   = 1'b1;
    mix_in  = 32'sd800;
    mute    = 1'b0;
    allowed = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_write", write_audio_out, 0);
    chk("reset_left", left_out, 0);
    chk("reset_right", right_out, 0);
    chk("reset_tick", sample_tick, 0);
    chk("reset_dropped", dropped_count, 0);
    reset = 1'b0;

    // Steady state
    do_tick(32'sd800, 1'b0, 1'b1, 32'd100, w);
    chk("first_tick_delay", w, DIV - 1);
    for (int i = 0; i < 3; i++) do_tick(32'sd800, 1'b0, 1'b1, 32'd100, w);
    chk("steady_dropped", dropped_count, 0);

    // Saturation and small negative
    do_tick(32'sh7FFFFFFF, 1'b0, 1'b1, 32'h007FFFFF, w);
    do_tick(32'sh80000000, 1'b0, 1'b1, 32'hFF800000, w);
    do_tick(-32'sd8, 1'b0, 1'b1, 32'hFFFFFFFF, w);

    // Mute
    do_tick(32'sd8000, 1'b1, 1'b1, 32'd0, w);
    do_tick(32'sd8000, 1'b0, 1'b1, 32'd1000, w);

    // Handshake edge: allowed drops during the WRITE cycle
    @(negedge clock);
    allowed = 1'b0;
    do_tick(32'sd16, 1'b0, 1'b1, 32'd2, w);
    lat_chk = 1'b0;
    do_tick(32'sd24, 1'b0, 1'b1, 32'd3, w);
    n0 = wr_cyc.size();
    allowed = 1'b1;
    @(negedge clock);
    allowed = 1'b0;
    do_tick(32'sd32, 1'b0, 1'b1, 32'd4, w);
    chk("write_survives_allowed_drop", wr_cyc.size(), n0 + 1);
    chk("strobe_held_while_blocked", write_audio_out, 0);
    allowed = 1'b1;
    do_tick(32'sd40, 1'b0, 1'b1, 32'd5, w);
    repeat (3) @(negedge clock);

    // Backpressure: six ticks with the codec blocked
    allowed = 1'b0;
    for (int i = 1; i <= 6; i++)
      do_tick(32'(8 * i), 1'b0, (i <= 4), 32'(i), w);
    chk("dropped_after_backpressure", dropped_count, 2);
    n0 = wr_cyc.size();
    allowed = 1'b1;
    do_tick(32'sd56, 1'b0, 1'b1, 32'd7, w);
    do_tick(32'sd64, 1'b0, 1'b1, 32'd8, w);
    do_tick(32'sd72, 1'b0, 1'b1, 32'd9, w);
    chk("drain_write_count", (wr_cyc.size() >= n0 + 4), 1);
    if (wr_cyc.size() >= n0 + 4)
      for (int k = 1; k < 4; k++) chk("drain_spacing", wr_cyc[n0 + k] - wr_cyc[n0 + k - 1], 3);

    // Reset with three samples buffered
    @(negedge clock);
    allowed = 1'b0;
    do_tick(32'sd80, 1'b0, 1'b1, 32'd10, w);
    chk("dropped_saturates", drop2, 2'b11);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    chk("midreset_write", write_audio_out, 0);
    chk("midreset_left", left_out, 0);
    chk("midreset_right", right_out, 0);
    chk("midreset_dropped", dropped_count, 0);
    chk("midreset_dropped2", drop2, 0);
    lat_chk = 1'b1;
    allowed = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    do_tick(32'sd800, 1'b0, 1'b1, 32'd100, w);
    chk("tick_delay_after_reset", w, DIV - 1);
    do_tick(-32'sd800, 1'b0, 1'b1, 32'hFFFFFF9C, w);
    repeat (4) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_dropped", dropped_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
